// File: rtl/stopwatch_counter_gen_pkg.sv
// Shared constants for the stopwatch core.
//   DIR_*  : encoding of the dir input (count direction)
//   SEL_*  : encoding of the sel input (field picked in adjust mode)
//   DEF_*  : default field width and field limits (mm:ss, 00..59)
package stopwatch_pkg;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic SEL_MIN  = 1'b0;
  localparam logic SEL_SEC  = 1'b1;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_MAX_MIN = 59;
  localparam int DEF_MAX_SEC = 59;
endpackage

// File: rtl/stopwatch_counter_gen_mod_counter.sv
// Single wrapping up/down field counter (0..MAX).
//   clk, rst : system clock, synchronous active-high reset
//   en       : take one step this cycle
//   dir      : DIR_UP = +1, DIR_DOWN = -1
//   value    : current field value
//   wrap     : combinational, high when the step being taken crosses
//              MAX->0 (up) or 0->MAX (down); used as carry/borrow
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  if (MAX >= 2**WIDTH) begin : g_chk
    $error("mod_counter: MAX does not fit in WIDTH bits");
  end

  logic at_top, at_bot;

  // >= so an out-of-range value can never run away past MAX
  assign at_top = (value >= MAX_V);
  assign at_bot = (value == '0);
  assign wrap   = en & ((dir == DIR_DOWN) ? at_bot : at_top);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (en) begin
      if (dir == DIR_DOWN) value <= at_bot ? MAX_V : value - 1'b1;
      else                 value <= at_top ? '0    : value + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_counter_gen.sv
// Minutes:seconds stopwatch/timer core.
//   clk, rst   : system clock, synchronous active-high reset
//   tick_1hz   : count enable (normal mode)
//   tick_2hz   : adjust enable (adjust mode), also drives blink
//   pse        : debounced pause level, rising edge toggles paused
//   adj        : 1 = adjust mode, 0 = normal mode
//   sel        : adjust field, SEL_MIN / SEL_SEC
//   dir        : DIR_UP / DIR_DOWN
//   min, sec   : current time
//   paused     : pause state
//   done       : one-cycle terminal-count pulse
//   blink      : blink phase for the selected field while adjusting
module stopwatch_counter_gen
  import stopwatch_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             pse,
  input  logic             adj,
  input  logic             sel,
  input  logic             dir,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] sec,
  output logic             paused,
  output logic             done,
  output logic             blink
);
  if (MAX_MIN >= 2**WIDTH || MAX_SEC >= 2**WIDTH) begin : g_chk
    $error("stopwatch_counter_gen: MAX_MIN/MAX_SEC do not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MAX_MIN_V = WIDTH'(MAX_MIN);
  localparam logic [WIDTH-1:0] MAX_SEC_V = WIDTH'(MAX_SEC);

  logic pse_d, pse_rise;
  logic run_tick, adj_tick;
  logic at_zero, at_max;
  logic auto_stop, roll_over;
  logic sec_en, min_en, sec_wrap, min_wrap;

  assign pse_rise = pse & ~pse_d;

  // Gating uses the registered (pre-toggle) paused value, so a pause edge
  // landing with a tick still lets that tick count.
  assign run_tick = ~adj & ~paused & tick_1hz;
  assign adj_tick = adj & tick_2hz;

  assign at_zero = (min == '0) && (sec == '0);
  assign at_max  = (min == MAX_MIN_V) && (sec == MAX_SEC_V);

  // Counting down from 00:00 holds and stops the timer instead of wrapping.
  assign auto_stop = run_tick & (dir == DIR_DOWN) & at_zero;
  assign roll_over = run_tick & (dir == DIR_UP) & at_max;

  // Adjust steps one field with no carry; normal mode chains sec->min.
  assign sec_en = adj_tick ? (sel == SEL_SEC) : (run_tick & ~auto_stop);
  assign min_en = adj_tick ? (sel == SEL_MIN) : sec_wrap;

  mod_counter #(.WIDTH(WIDTH), .MAX(MAX_SEC)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .en    (sec_en),
    .dir   (dir),
    .value (sec),
    .wrap  (sec_wrap)
  );

  mod_counter #(.WIDTH(WIDTH), .MAX(MAX_MIN)) u_min (
    .clk   (clk),
    .rst   (rst),
    .en    (min_en),
    .dir   (dir),
    .value (min),
    .wrap  (min_wrap)
  );

  // Minute wrap is implied by at_max/at_zero; kept for observability only.
  logic min_wrap_unused;
  assign min_wrap_unused = min_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      pse_d  <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
      blink  <= 1'b0;
    end else begin
      pse_d <= pse;
      done  <= auto_stop | roll_over;
      // auto-stop wins over a simultaneous pause toggle: the timer must stop
      if (auto_stop)     paused <= 1'b1;
      else if (pse_rise) paused <= ~paused;
      blink <= adj ? (blink ^ tick_2hz) : 1'b0;
    end
  end
endmodule
